reset_request_gen: RTL

//  Front end for the reset controller: converts raw, bouncing reset sources into clean reset requests.
//  - Synchronises and debounces the active-low board button.
//  - Merges the button with a single-cycle software reset request.
//  - Emits a fixed-width active-low request pulse on rst_req_n, wired to the reset controller's fpga_but1.
//  - Sits between the board pins / system bus and the reset controller.

---
 rtl/reset_request_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/reset_request_gen.sv
// reset_request_gen: synchronises and debounces the board reset button, merges it with a
// single-cycle software request and emits a fixed-width active-low request pulse.
// Optional long-press detector is built only when the macro LONG_PRESS_EN is defined.
module reset_request_gen #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int REQ_PULSE_CYCLES  = 16,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic sw_req,
  output logic rst_req_n,
  output logic btn_held,
  output logic busy,
  output logic long_press
);

  localparam int MAX_CNT = (DEBOUNCE_CYCLES > REQ_PULSE_CYCLES) ? DEBOUNCE_CYCLES : REQ_PULSE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(REQ_PULSE_CYCLES - 1);

  if ((SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 2) || (REQ_PULSE_CYCLES < 1) ||
      (LONG_PRESS_CYCLES < 1)) begin : g_bad_params
    $error("reset_request_gen: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    PULSE    = 3'd2,
    HELD     = 3'd3,
    REL_DB   = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   src_btn_q, src_btn_d;
  logic                   in_press_s;
  logic                   lp_fire_s;
  logic                   rst_req_n_q, btn_held_q, busy_q, long_press_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Button synchroniser; every stage idles at the released level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // FSM state, shared debounce/pulse counter and request source
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      src_btn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_btn_q <= src_btn_d;
    end
  end

  // Next-state logic; the single counter is reused for both debounce and pulse width
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_btn_d = src_btn_q;
    case (state_q)
      IDLE: begin
        if (sw_req) begin
          state_d   = PULSE;
          cnt_d     = CNT_ZERO;
          src_btn_d = 1'b0;
        end else if (!btn_s) begin
          state_d = PRESS_DB;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS_DB: begin
        if (btn_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d   = PULSE;
          cnt_d     = CNT_ZERO;
          src_btn_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = src_btn_q ? HELD : IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      HELD: begin
        if (btn_s) begin
          state_d = REL_DB;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = HELD;
        end
      end
      REL_DB: begin
        if (!btn_s) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = CNT_ZERO;
        src_btn_d = 1'b0;
      end
    endcase
  end

  assign in_press_s = ((state_q == PULSE) && src_btn_q) || (state_q == HELD) || (state_q == REL_DB);

`ifdef LONG_PRESS_EN
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1) + 1;

  localparam logic [LP_W-1:0] LP_ZERO   = {LP_W{1'b0}};
  localparam logic [LP_W-1:0] LP_ONE    = {{(LP_W-1){1'b0}}, 1'b1};
  localparam logic [LP_W-1:0] LP_TARGET = LP_W'(LONG_PRESS_CYCLES);

  logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
  logic            pulse_entry_s;

  assign pulse_entry_s = (state_d == PULSE) && (state_q != PULSE);

  // Hold-time counter: restarts on every PULSE entry and parks at the target
  always_comb begin
    lp_cnt_d = lp_cnt_q;
    if (pulse_entry_s) begin
      lp_cnt_d = LP_ZERO;
    end else if (in_press_s && (lp_cnt_q != LP_TARGET)) begin
      lp_cnt_d = lp_cnt_q + LP_ONE;
    end else begin
      lp_cnt_d = lp_cnt_q;
    end
  end

  // Hold-time counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      lp_cnt_q <= LP_ZERO;
    end else begin
      lp_cnt_q <= lp_cnt_d;
    end
  end

  assign lp_fire_s = (lp_cnt_d == LP_TARGET) && (lp_cnt_q != LP_TARGET);
`else
  assign lp_fire_s = 1'b0;
`endif

  // Registered output decode of the current state
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_req_n_q  <= 1'b1;
      btn_held_q   <= 1'b0;
      busy_q       <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      rst_req_n_q  <= (state_q != PULSE);
      btn_held_q   <= in_press_s;
      busy_q       <= (state_q != IDLE);
      long_press_q <= lp_fire_s;
    end
  end

  assign rst_req_n  = rst_req_n_q;
  assign btn_held   = btn_held_q;
  assign busy       = busy_q;
  assign long_press = long_press_q;

endmodule
